// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES request arbiter.
`default_nettype none

package aes_arb_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/aes_req_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, search starts after last_grant
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    // k = N wraps back onto last_grant itself, so it is the lowest priority
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_req_arbiter.sv
// ---------------------------------------------------------------------------
// aes_req_arbiter : shares one iterative AES-128 core among N_REQ requesters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*AES_BLK_W-1:0] req_plaintext,
  input  logic [N_REQ*AES_BLK_W-1:0] req_key,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [AES_BLK_W-1:0]       rsp_data,
  output logic                       rsp_err,
  output logic                       core_start,
  output logic [AES_BLK_W-1:0]       core_plaintext,
  output logic [AES_BLK_W-1:0]       core_key,
  input  logic [AES_BLK_W-1:0]       core_ciphertext,
  input  logic                       core_valid,
  output logic                       busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t           state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      job_id_q, job_id_d;
  logic [AES_BLK_W-1:0] op_pt_q, op_pt_d;
  logic [AES_BLK_W-1:0] op_key_q, op_key_d;
  logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;

  logic [N_REQ-1:0]     arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;
  logic [AES_BLK_W-1:0] sel_pt, sel_key;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  always_comb begin
    sel_pt  = '0;
    sel_key = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_pt  = req_plaintext[i*AES_BLK_W +: AES_BLK_W];
        sel_key = req_key[i*AES_BLK_W +: AES_BLK_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    job_id_d     = job_id_q;
    op_pt_d      = op_pt_q;
    op_key_d     = op_key_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    wdog_d       = wdog_q;
    req_ready    = '0;
    core_start   = 1'b0;

    case (state_q)
      IDLE: begin
        // rst gate keeps req_ready low while the async reset is held
        if (arb_any && !rst) begin
          req_ready = arb_grant;
          op_pt_d   = sel_pt;
          op_key_d  = sel_key;
          job_id_d  = arb_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        wdog_d     = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wdog_q != '1) wdog_d = wdog_q + 1'b1;
        // wdog_q == WD_LAST marks the TIMEOUT_CYCLES-th WAIT cycle; a done
        // pulse in that same cycle still takes priority
        if (core_valid) begin
          rsp_data_d = core_ciphertext;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wdog_q >= WD_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          last_grant_d = job_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      job_id_q     <= '0;
      op_pt_q      <= '0;
      op_key_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      job_id_q     <= job_id_d;
      op_pt_q      <= op_pt_d;
      op_key_q     <= op_key_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      wdog_q       <= wdog_d;
    end
  end

  assign rsp_valid      = (state_q == RESP);
  assign rsp_id         = job_id_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign core_plaintext = op_pt_q;
  assign core_key       = op_key_q;
  assign busy           = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a behavioural AES core stand-in.
`default_nettype none

module tb_aes_req_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 16;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*128-1:0] req_plaintext, req_key;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]   rsp_id;
  logic [127:0]     rsp_data;
  logic             core_start, core_valid, busy;
  logic [127:0]     core_plaintext, core_key, core_ciphertext;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_req_arbiter #(
    .N_REQ          (N),
    .ID_W           (IDW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_plaintext   (req_plaintext),
    .req_key         (req_key),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .core_start      (core_start),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_ciphertext (core_ciphertext),
    .core_valid      (core_valid),
    .busy            (busy)
  );

  function automatic logic [127:0] fake_aes(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] pt_of(input int i, input int j);
    if (i == 0 && j == 0) return FIPS_PT;
    return {i[7:0], j[23:0], 96'h0123_4567_89ab_cdef_0011_2233};
  endfunction

  function automatic logic [127:0] key_of(input int i, input int j);
    if (i == 0 && j == 0) return FIPS_KEY;
    return {96'hdead_beef_cafe_f00d_1357_9bdf, i[7:0], j[23:0]};
  endfunction

  // Core stand-in: done pulse lands stub_lat cycles after the start cycle
  int           stub_lat  = 5;
  bit           stub_hang = 1'b0;
  int           stub_cnt  = 0;
  logic         stub_valid = 1'b0;
  logic         spur_valid = 1'b0;
  logic [127:0] stub_ct    = '0;

  assign core_valid      = stub_valid | spur_valid;
  assign core_ciphertext = stub_ct;

  always @(negedge clk) begin
    stub_valid = 1'b0;
    if (rst) begin
      stub_cnt = 0;
    end else begin
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_valid = 1'b1;
          stub_ct    = fake_aes(core_plaintext, core_key);
        end
      end
      if (core_start && !stub_hang) stub_cnt = stub_lat;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load_all(input int j);
    for (int i = 0; i < N; i++) begin
      req_plaintext[i*128 +: 128] = pt_of(i, j);
      req_key[i*128 +: 128]       = key_of(i, j);
    end
  endtask

  // Called in an IDLE cycle; accepts, runs and drains one job.
  task automatic run_job(input logic [N-1:0] mask, input int exp_id, input int lat,
                         input bit hang, input int bp);
    logic [127:0]   ept, ekey, ect, spt, skey;
    logic [N-1:0]   exp_rdy;
    int             n, starts;
    stub_lat  = lat;
    stub_hang = hang;
    rsp_ready = (bp == 0);
    req_valid = mask;
    #1;
    exp_rdy = N'(1) << exp_id;
    chk("accept_ready", req_ready, exp_rdy);
    ept  = req_plaintext[exp_id*128 +: 128];
    ekey = req_key[exp_id*128 +: 128];
    ect  = hang ? 128'h0 : fake_aes(ept, ekey);
    spt  = req_plaintext;
    skey = req_key;
    cyc();
    req_plaintext = ~req_plaintext;
    req_key       = ~req_key;
    #1;
    chk("core_start", core_start, 1);
    chk("ready_in_issue", req_ready, 0);
    chk("core_pt", core_plaintext, ept);
    chk("core_key", core_key, ekey);
    starts = 1;
    n      = 0;
    while (!rsp_valid && n < 100) begin
      cyc();
      #1;
      n++;
      if (core_start) starts++;
    end
    chk("rsp_latency", n, hang ? TO + 1 : lat + 1);
    chk("start_once", starts, 1);
    chk("rsp_id", rsp_id, exp_id);
    chk("rsp_data", rsp_data, ect);
    chk("rsp_err", rsp_err, hang);
    chk("core_pt_held", core_plaintext, ept);
    for (int k = 0; k < bp; k++) begin
      cyc();
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, exp_id);
      chk("bp_data", rsp_data, ect);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    cyc();
    req_plaintext[127:0] = spt[127:0];
    req_plaintext = spt;
    req_key       = skey;
    chk("rsp_dropped", rsp_valid, 0);
    chk("idle_again", busy, 0);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           id;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl[0]  = '{4'b1111, 1};
    tbl[1]  = '{4'b1111, 2};
    tbl[2]  = '{4'b1111, 3};
    tbl[3]  = '{4'b1111, 0};
    tbl[4]  = '{4'b1111, 1};
    tbl[5]  = '{4'b1010, 3};
    tbl[6]  = '{4'b1010, 1};
    tbl[7]  = '{4'b0101, 2};
    tbl[8]  = '{4'b0101, 0};
    tbl[9]  = '{4'b0100, 2};
    tbl[10] = '{4'b1001, 3};
    tbl[11] = '{4'b1001, 0};
    tbl[12] = '{4'b0110, 1};

    rst           = 1'b1;
    req_valid     = '0;
    rsp_ready     = 1'b0;
    req_plaintext = '0;
    req_key       = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_pt", core_plaintext, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    cyc();

    // FIPS-197 vector on requester 0
    load_all(0);
    run_job(4'b0001, 0, 5, 1'b0, 0);
    chk("fips_ct", rsp_data, FIPS_CT);

    // Round-robin table with requests held through each job
    for (int v = 0; v < 13; v++) begin
      load_all(v + 1);
      run_job(tbl[v].mask, tbl[v].id, 3 + (v % 4), 1'b0, 0);
    end

    // Response backpressure: 20 stalled cycles, then the next grant follows
    load_all(20);
    run_job(4'b1111, 2, 4, 1'b0, 19);
    run_job(4'b1111, 3, 4, 1'b0, 0);

    // Hung core hits the watchdog, next job is normal
    load_all(21);
    run_job(4'b0010, 1, 5, 1'b1, 0);
    run_job(4'b0011, 0, 5, 1'b0, 0);

    // Done pulse in the very cycle the watchdog expires
    run_job(4'b0100, 2, TO, 1'b0, 0);

    // Spurious done pulse while idle
    req_valid  = '0;
    spur_valid = 1'b1;
    cyc();
    spur_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("spur_no_rsp", rsp_valid, 0);
      chk("spur_idle", busy, 0);
      cyc();
    end

    // Reset while waiting on the core
    stub_lat  = 5;
    req_valid = 4'b1000;
    #1;
    chk("pre_rst_ready", req_ready, 4'b1000);
    cyc();
    cyc();
    cyc();
    chk("pre_rst_busy", busy, 1);
    rst       = 1'b1;
    req_valid = 4'b0101;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_core_pt", core_plaintext, 0);
    chk("mid_rst_core_key", core_key, 0);
    chk("mid_rst_core_start", core_start, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_id", rsp_id, 0);
    cyc();
    rst = 1'b0;
    run_job(4'b0101, 0, 5, 1'b0, 0);
    run_job(4'b0101, 2, 5, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
- Shares one iterative AES-128 encryption core (aes_top) between N_REQ independent requesters.
- Round-robin arbitration; per-requester valid/ready request channel; single response channel carrying ciphertext and requester ID.
- Sequences the core's start pulse, holds its operands stable for the whole job, and recovers from a hung core via a watchdog timeout.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of rsp_id.
- TIMEOUT_CYCLES, 255, max cycles in WAIT before the job is aborted with an error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_plaintext  in  N_REQ*128  packed; requester i at [i*128 +: 128]
- req_key  in  N_REQ*128  packed; same layout
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester owning the response
- rsp_data  out  128  ciphertext (all zeros on error)
- rsp_err  out  1  job aborted by timeout
- core_start  out  1  start pulse to core
- core_plaintext  out  128  to core, held for entire job
- core_key  out  128  to core, held for entire job
- core_ciphertext  in  128  from core
- core_valid  in  1  from core, single-cycle done pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, core_start=0, core_plaintext=0, core_key=0, busy=0, last_grant=N_REQ-1, so requester 0 has top priority after reset.
- Reset mid-job aborts silently: no response is produced. The core shares rst, so it returns to idle as well.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, the winner g is the first set bit searched from last_grant+1 upward, wrapping modulo N_REQ.
  - req_ready[g]=1 combinationally that same cycle; the handshake completes there.
  - Latch pt/key of g into operand registers, latch g as job_id, go to ISSUE.
  - req_ready is never asserted outside IDLE.
- ISSUE: core_start=1 for exactly one cycle; clear watchdog counter; go to WAIT.
- WAIT:
  - Increment watchdog each cycle.
  - On core_valid: capture core_ciphertext into rsp_data, rsp_err=0, go to RESP.
  - If watchdog reaches TIMEOUT_CYCLES with no core_valid: rsp_data=0, rsp_err=1, go to RESP.
  - If core_valid arrives in the same cycle as the timeout, core_valid wins.
  - core_valid seen in any state other than WAIT is ignored.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_data and rsp_err held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid deasserts next cycle, last_grant<=job_id, state goes to IDLE.
  - New requests are not accepted during RESP (one job outstanding at a time).
- core_plaintext and core_key are driven from the operand registers. They change only on an IDLE acceptance and are stable from ISSUE through RESP.
- Latency: acceptance at cycle T, core_start at T+1, rsp_valid on the cycle after core_valid. The next acceptance is possible no earlier than the cycle after the response handshake.
- Fairness: a requester holding req_valid continuously waits at most N_REQ-1 jobs.
- A requester deasserting req_valid before its grant is legal; it simply loses its turn.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.

Decomposition:
- Package aes_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, RESP}
  - localparam AES_BLK_W=128
  - default TIMEOUT constant
- Sub-module rr_arbiter (parameter N): purely combinational one-hot grant from req vector and last_grant pointer.
- Top-level holds the FSM, operand/response registers and watchdog.

Test Plan:
- FIPS-197 single job: req 0, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> one rsp with rsp_id=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0; core_start pulses once.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,...; every rsp_id matches its originating pt/key.
- Response backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_data held stable; no req_ready asserted; IDLE resumes after the handshake.
- Hung-core stub (core_valid never asserted), TIMEOUT_CYCLES=16 -> rsp_valid with rsp_err=1, rsp_data=0 exactly 16 cycles after WAIT entry; next job proceeds normally.
- rst asserted mid-WAIT -> all outputs zero immediately; after release, requesters 0 and 2 both valid -> requester 0 granted first.
- core_valid coincident with timeout expiry -> rsp_err=0 and ciphertext returned; spurious core_valid in IDLE -> no response.
